blink_led_arbiter: RTL and testbench

// - Shares one status LED among N_REQ requesters, each of which asks for a burst of K blinks.
// - A free-running prescaler produces the blink timebase (tick).
// - Round-robin arbitration grants the LED to one requester at a time.
// - A sequencer FSM drives the LED ON/OFF per tick, then holds a dark gap before the next owner.
// - Sits between status sources (error, link, activity) and the board LED pin.

---
 rtl/blink_led_arbiter.sv | 171 +++++++++++++++++
 tb/tb_blink_led_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_led_arbiter.sv
// Shares one status LED among N_REQ requesters, each asking for a burst of blinks.
// Optional macro BLINK_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module blink_led_arbiter #(
  parameter int N_REQ      = 4,
  parameter int HALF_TICKS = 24,
  parameter int BLINK_W    = 4,
  parameter int GAP_TICKS  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BLINK_W-1:0]   blinks,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       led,
  output logic                       tick,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HALF_TICKS);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ON,
    OFF,
    GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic [BLINK_W-1:0] remaining;
  logic [GAP_W-1:0]   gapcnt;
  logic               aborted;
`ifndef BLINK_FIXED_PRIO_EN
  logic [IDX_W-1:0]   rr;
`endif

  // Free-running timebase; tick is registered and never gated by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(HALF_TICKS - 1));
      if (cnt == CNT_W'(HALF_TICKS - 1))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

`ifdef BLINK_FIXED_PRIO_EN
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick       = IDX_W'(i);
        pick_valid = 1'b1;
      end
    end
  end
`else
  // Scan downward so the last hit is the closest index after rr.
  always_comb begin
    logic [IDX_W-1:0] idx;
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(rr) + k) % N_REQ);
      if (req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      led       <= 1'b0;
      owner     <= '0;
      remaining <= '0;
      gapcnt    <= '0;
      aborted   <= 1'b0;
`ifndef BLINK_FIXED_PRIO_EN
      rr        <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      done <= '0;
      // An owner dropping its request beats a simultaneous tick.
      if ((state == WAIT || state == ON || state == OFF) && !req[owner]) begin
        led     <= 1'b0;
        gapcnt  <= GAP_W'(GAP_TICKS);
        aborted <= 1'b1;
        state   <= GAP;
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              gnt        <= '0;
              gnt[pick]  <= 1'b1;
              owner      <= pick;
`ifndef BLINK_FIXED_PRIO_EN
              rr         <= pick;
`endif
              remaining  <= blinks[pick*BLINK_W +: BLINK_W];
              aborted    <= 1'b0;
              state      <= WAIT;
            end
          end
          WAIT, OFF: begin
            if (tick) begin
              if (remaining == '0) begin
                gapcnt <= GAP_W'(GAP_TICKS);
                state  <= GAP;
              end else begin
                led   <= 1'b1;
                state <= ON;
              end
            end
          end
          ON: begin
            if (tick) begin
              led <= 1'b0;
              if (remaining != '0)
                remaining <= remaining - 1'b1;
              state <= OFF;
            end
          end
          GAP: begin
            if (tick) begin
              if (gapcnt != '0)
                gapcnt <= gapcnt - 1'b1;
              if (gapcnt <= GAP_W'(1)) begin
                if (!aborted)
                  done[owner] <= 1'b1;
                gnt   <= '0;
                state <= IDLE;
              end
            end
          end
          default: begin
            led   <= 1'b0;
            gnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  led_only_on: assert property (@(posedge clk) disable iff (rst) led |-> (state == ON));
  done_drops_gnt: assert property (@(posedge clk) disable iff (rst) (done != '0) |-> (gnt == '0));
`endif

endmodule

// File: tb/tb_blink_led_arbiter.sv
// Directed self-checking bench for blink_led_arbiter (N_REQ=4, HALF_TICKS=4, GAP_TICKS=2, BLINK_W=4).
// Build with BLINK_FIXED_PRIO_EN defined to check the fixed-priority grant order instead.
module tb_blink_led_arbiter;

  localparam int N_REQ      = 4;
  localparam int HALF_TICKS = 4;
  localparam int BLINK_W    = 4;
  localparam int GAP_TICKS  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] blinks;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        led;
  logic        tick;
  logic        busy;

  int total = 0;
  int bad   = 0;

  blink_led_arbiter #(
    .N_REQ(N_REQ),
    .HALF_TICKS(HALF_TICKS),
    .BLINK_W(BLINK_W),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .blinks(blinks),
    .gnt(gnt),
    .done(done),
    .led(led),
    .tick(tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Bounded wait for a tick visible at a falling edge (current cycle counts).
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2*HALF_TICKS + 2; k++) begin
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst = 1'b1; req = '0; blinks = '0;
    @(negedge clk); @(negedge clk);
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
    total++; if (done !== 4'b0000) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
    total++; if (led !== 1'b0) begin bad++; $display("[TB] FAIL reset_led: got %b expected 0", led); end
    total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      exp_tick = (j == 4);
      total++;
      if (tick !== exp_tick) begin bad++; $display("[TB] FAIL tick_phase j=%0d: got %b expected %b", j, tick, exp_tick); end
    end
  endtask

  task automatic test_single();
    bit ok;
    int errs;
    logic exp_led, exp_tick;
    logic [3:0] exp_gnt, exp_done, gnt32, gnt33, done33;
    logic busy34;
    errs = 0; gnt32 = 'x; gnt33 = 'x; done33 = 'x; busy34 = 'x;
    blinks = 16'h0003; req = 4'b0001;
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL single_grant: got %b expected 0001", gnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    total++; if (led !== 1'b0) begin bad++; $display("[TB] FAIL single_led_wait: got %b expected 0", led); end
    blinks = 16'hFFF9;
    wait_tick(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL single_tick_timeout: got none expected tick"); end
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      exp_led  = (j >= 1 && j <= 4) || (j >= 9 && j <= 12) || (j >= 17 && j <= 20);
      exp_tick = (j % 4 == 0);
      exp_gnt  = (j <= 32) ? 4'b0001 : 4'b0000;
      exp_done = (j == 33) ? 4'b0001 : 4'b0000;
      if (led !== exp_led) errs++;
      if (tick !== exp_tick) errs++;
      if (gnt !== exp_gnt) errs++;
      if (done !== exp_done) errs++;
      if (j == 32) gnt32 = gnt;
      if (j == 33) begin gnt33 = gnt; done33 = done; end
      if (j == 34) busy34 = busy;
      if (j == 26) req = 4'b0000;
    end
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL single_pattern: got %0d bad cycles expected 0", errs); end
    total++; if (gnt32 !== 4'b0001) begin bad++; $display("[TB] FAIL single_gnt_gap_end: got %b expected 0001", gnt32); end
    total++; if (done33 !== 4'b0001) begin bad++; $display("[TB] FAIL single_done: got %b expected 0001", done33); end
    total++; if (gnt33 !== 4'b0000) begin bad++; $display("[TB] FAIL single_gnt_release: got %b expected 0000", gnt33); end
    total++; if (busy34 !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after: got %b expected 0", busy34); end
  endtask

  task automatic test_zero_count();
    bit ok;
    int errs;
    logic [3:0] exp_gnt, exp_done, done9;
    logic busy10;
    errs = 0; done9 = 'x; busy10 = 'x;
    blinks = 16'h0000; req = 4'b0100;
    @(negedge clk);
    total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL zero_grant: got %b expected 0100", gnt); end
    wait_tick(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL zero_tick_timeout: got none expected tick"); end
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      exp_gnt  = (j <= 8) ? 4'b0100 : 4'b0000;
      exp_done = (j == 9) ? 4'b0100 : 4'b0000;
      if (led !== 1'b0) errs++;
      if (gnt !== exp_gnt) errs++;
      if (done !== exp_done) errs++;
      if (j == 9) done9 = done;
      if (j == 10) busy10 = busy;
      if (j == 2) req = 4'b0000;
    end
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL zero_pattern: got %0d bad cycles expected 0", errs); end
    total++; if (done9 !== 4'b0100) begin bad++; $display("[TB] FAIL zero_done: got %b expected 0100", done9); end
    total++; if (busy10 !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_after: got %b expected 0", busy10); end
  endtask

  task automatic test_round_robin();
    logic [3:0] grants [4];
    logic [3:0] exp_order [4];
    logic [3:0] prev, first_done;
    int n, zero_run, done_cnt;
    bit idle_ok;
`ifdef BLINK_FIXED_PRIO_EN
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0001; exp_order[2] = 4'b0001; exp_order[3] = 4'b0001;
`else
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b1000; exp_order[3] = 4'b0001;
`endif
    for (int i = 0; i < 4; i++) grants[i] = 'x;
    n = 0; zero_run = 0; done_cnt = 0; prev = '0; first_done = 'x;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; blinks = 16'h1111; req = 4'b1011;
    for (int c = 0; c < 300 && n < 4; c++) begin
      @(negedge clk);
      if (done != 4'b0000) begin
        if (done_cnt == 0) first_done = done;
        done_cnt++;
      end
      if (gnt != 4'b0000 && prev == 4'b0000) begin
        grants[n] = gnt;
        n++;
      end else if (gnt == 4'b0000 && n > 0) begin
        zero_run++;
      end
      prev = gnt;
    end
    total++; if (n !== 4) begin bad++; $display("[TB] FAIL rr_timeout: got %0d grants expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (grants[i] !== exp_order[i]) begin bad++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, grants[i], exp_order[i]); end
    end
    total++; if (done_cnt !== 3) begin bad++; $display("[TB] FAIL rr_done_count: got %0d expected 3", done_cnt); end
    total++; if (first_done !== 4'b0001) begin bad++; $display("[TB] FAIL rr_first_done: got %b expected 0001", first_done); end
    total++; if (zero_run !== 3) begin bad++; $display("[TB] FAIL rr_handover_cycles: got %0d expected 3", zero_run); end
    req = 4'b0000;
    idle_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy === 1'b0 && gnt === 4'b0000) begin idle_ok = 1'b1; break; end
    end
    total++; if (!idle_ok) begin bad++; $display("[TB] FAIL rr_drain_timeout: got busy=%b expected 0", busy); end
  endtask

  task automatic test_abort();
    bit ok;
    int errs;
    logic exp_led;
    logic [3:0] exp_gnt, gnt20, gnt21;
    logic led12, led13, busy22;
    errs = 0; gnt20 = 'x; gnt21 = 'x; led12 = 'x; led13 = 'x; busy22 = 'x;
    blinks = 16'h0050; req = 4'b0010;
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL abort_grant: got %b expected 0010", gnt); end
    wait_tick(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL abort_tick_timeout: got none expected tick"); end
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      exp_led = (j >= 1 && j <= 4) || (j >= 9 && j <= 12);
      exp_gnt = (j <= 20) ? 4'b0010 : 4'b0000;
      if (led !== exp_led) errs++;
      if (gnt !== exp_gnt) errs++;
      if (done !== 4'b0000) errs++;
      if (j == 12) led12 = led;
      if (j == 13) led13 = led;
      if (j == 20) gnt20 = gnt;
      if (j == 21) gnt21 = gnt;
      if (j == 22) busy22 = busy;
      if (j == 12) req = 4'b0000;
    end
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL abort_pattern: got %0d bad cycles expected 0", errs); end
    total++; if (led12 !== 1'b1) begin bad++; $display("[TB] FAIL abort_second_on: got %b expected 1", led12); end
    total++; if (led13 !== 1'b0) begin bad++; $display("[TB] FAIL abort_led_off: got %b expected 0", led13); end
    total++; if (gnt20 !== 4'b0010) begin bad++; $display("[TB] FAIL abort_gnt_held: got %b expected 0010", gnt20); end
    total++; if (gnt21 !== 4'b0000) begin bad++; $display("[TB] FAIL abort_gnt_release: got %b expected 0000", gnt21); end
    total++; if (busy22 !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle: got %b expected 0", busy22); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    blinks = 16'h0300; req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (led === 1'b1) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL midrst_led_timeout: got led=%b expected 1", led); end
    rst = 1'b1;
    #1;
    total++; if (led !== 1'b0) begin bad++; $display("[TB] FAIL midrst_led: got %b expected 0", led); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_gnt: got %b expected 0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tick: got %b expected 0", tick); end
    total++; if (done !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_done: got %b expected 0000", done); end
    req = 4'b1111; blinks = 16'h1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL midrst_first_grant: got %b expected 0001", gnt); end
    total++; if (done !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_no_done: got %b expected 0000", done); end
  endtask

  initial begin
    rst = 1'b1; req = '0; blinks = '0;
    test_reset();
    test_single();
    test_zero_count();
    test_round_robin();
    test_abort();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
